// File: rtl/lcd_ctrl_if.sv
// Byte push channel from the LSU peripheral decode into the LCD controller.
// Latency: n/a (signal bundle only).
// Backpressure: wr_ready low means the command FIFO is full; a push offered then is dropped.
//
// Signals:
//   wr_valid  push request from the LSU
//   wr_data   [8] = RS (0 command, 1 data), [7:0] = byte
//   wr_ready  command FIFO not full
interface lcd_ctrl_if;
    logic       wr_valid;
    logic [8:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style 8-bit LCD sequencer: pops queued bytes and strobes RS/DATA/EN with timed setup, pulse, hold and wait.
// Latency: a byte pushed into an empty idle controller reaches the pins one edge after the push; EN rises SETUP_CYC edges later.
// Backpressure: wr_ready drops while the command FIFO holds FIFO_DEPTH entries; a push offered while full is dropped.
//
// Ports:
//   i_clk, i_rst   clock (rising edge) and synchronous active-high reset
//   wr             lcd_ctrl_if.slave push channel (wr_valid / wr_data / wr_ready)
//   o_busy         sequencer not idle or FIFO non-empty
//   o_init_done    controller is allowed to pop the FIFO
//   o_fifo_count   current FIFO occupancy
//   o_lcd_on, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_data   LCD pins (RW is always 0, write-only)
//
// Optional feature macro: LCD_INIT_EN
//   Defined:   after reset wait PWRUP_CYC cycles, then send 0x38, 0x0C, 0x01, 0x06 before serving the FIFO.
//   Undefined: no power-up sequence; o_init_done is tied high.
module lcd_ctrl #(
    parameter int FIFO_DEPTH = 8,
    parameter int SETUP_CYC  = 2,
    parameter int EN_CYC     = 12,
    parameter int HOLD_CYC   = 2,
    parameter int EXEC_CYC   = 2000,
    parameter int CLR_CYC    = 82000,
    parameter int PWRUP_CYC  = 750000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    lcd_ctrl_if.slave                     wr,
    output logic                          o_busy,
    output logic                          o_init_done,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_lcd_on,
    output logic                          o_lcd_rs,
    output logic                          o_lcd_rw,
    output logic                          o_lcd_en,
    output logic [7:0]                    o_lcd_data
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    // The single down-counter must hold the largest programmed interval.
    localparam int MAX_A   = (SETUP_CYC > EN_CYC)   ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (HOLD_CYC  > EXEC_CYC) ? HOLD_CYC  : EXEC_CYC;
    localparam int MAX_C   = (CLR_CYC   > PWRUP_CYC) ? CLR_CYC  : PWRUP_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef struct packed {
        logic       rs;
        logic [7:0] dat;
    } lcd_cmd_t;

    typedef logic [CNT_W-1:0] cnt_t;

`ifdef LCD_INIT_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT,
        S_PWRUP,
        S_INIT
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;
`endif

    localparam logic [PTR_W:0] FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam cnt_t           CNT_ONE   = cnt_t'(1);

    // ---------------------------------------------------------------
    // Command FIFO
    // ---------------------------------------------------------------
    lcd_cmd_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              wr_ready_w;
    logic              push;
    logic              pop;
    lcd_cmd_t          head;

    // Ready comes from the registered count only, so a pop in the same
    // cycle never frees a slot for a push offered while full.
    assign wr_ready_w  = (count != FIFO_FULL);
    assign wr.wr_ready = wr_ready_w;
    assign push        = wr.wr_valid && wr_ready_w;
    assign head        = mem[rd_ptr];

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= lcd_cmd_t'(wr.wr_data);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    state_t      state;
    cnt_t        cnt;
    logic        clr_q;      // byte on the pins needs the long clear/home wait
    logic        en_q;
    logic        rs_q;
    logic [7:0]  dat_q;
    logic        init_ok;

    // Clear display (0x01) is the only byte matching this rule; it gets CLR_CYC.
    function automatic logic is_clr(input logic rs, input logic [7:0] dat);
        return !rs && (dat[7:1] == 7'd0) && (dat != 8'd0);
    endfunction

`ifdef LCD_INIT_EN
    logic [1:0]  init_idx;
    logic        init_done_q;

    // Function set 8-bit/2-line, display on, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    assign init_ok = init_done_q;
`else
    assign init_ok = 1'b1;
`endif

    assign pop = (state == S_IDLE) && (count != '0) && init_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_q  <= 1'b0;
            rs_q  <= 1'b0;
            dat_q <= 8'd0;
            clr_q <= 1'b0;
`ifdef LCD_INIT_EN
            state       <= S_PWRUP;
            cnt         <= cnt_t'(PWRUP_CYC);
            init_idx    <= 2'd0;
            init_done_q <= 1'b0;
`else
            state <= S_IDLE;
            cnt   <= '0;
`endif
        end else begin
            case (state)
                // RS/DATA only ever change here, so they keep their last
                // value for as long as the sequencer sits idle.
                S_IDLE: begin
                    if (pop) begin
                        rs_q  <= head.rs;
                        dat_q <= head.dat;
                        clr_q <= is_clr(head.rs, head.dat);
                        cnt   <= cnt_t'(SETUP_CYC);
                        state <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    if (cnt == CNT_ONE) begin
                        en_q  <= 1'b1;
                        cnt   <= cnt_t'(EN_CYC);
                        state <= S_PULSE;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_PULSE: begin
                    if (cnt == CNT_ONE) begin
                        en_q  <= 1'b0;
                        cnt   <= cnt_t'(HOLD_CYC);
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_HOLD: begin
                    if (cnt == CNT_ONE) begin
                        cnt   <= clr_q ? cnt_t'(CLR_CYC) : cnt_t'(EXEC_CYC);
                        state <= S_WAIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                S_WAIT: begin
                    if (cnt == CNT_ONE) begin
`ifdef LCD_INIT_EN
                        if (!init_done_q) begin
                            if (init_idx == 2'd3) begin
                                init_done_q <= 1'b1;
                                state       <= S_IDLE;
                            end else begin
                                init_idx <= init_idx + 2'd1;
                                state    <= S_INIT;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
`else
                        state <= S_IDLE;
`endif
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

`ifdef LCD_INIT_EN
                S_PWRUP: begin
                    if (cnt == CNT_ONE) begin
                        state <= S_INIT;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end

                // Internal init bytes use the same strobe path as FIFO bytes.
                S_INIT: begin
                    rs_q  <= 1'b0;
                    dat_q <= init_byte(init_idx);
                    clr_q <= is_clr(1'b0, init_byte(init_idx));
                    cnt   <= cnt_t'(SETUP_CYC);
                    state <= S_SETUP;
                end
`endif

                default: begin
                    en_q  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    assign o_busy       = (state != S_IDLE) || (count != '0);
    assign o_init_done  = init_ok;
    assign o_fifo_count = count;
    assign o_lcd_on     = 1'b1;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_rs     = rs_q;
    assign o_lcd_en     = en_q;
    assign o_lcd_data   = dat_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: timestamp-based reference model plus directed timing scenarios and random traffic.
// Latency: n/a.
// Backpressure: drives pushes regardless of ready; the model decides which pushes are accepted.
module tb_lcd_ctrl;

    localparam int DEPTH = 4;
    localparam int S     = 2;
    localparam int E     = 4;
    localparam int H     = 2;
    localparam int X     = 10;
    localparam int C     = 50;
    localparam int PW    = 20;

`ifdef LCD_INIT_EN
    localparam logic RST_BUSY = 1'b1;
`else
    localparam logic RST_BUSY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic                       busy;
    logic                       init_done;
    logic [$clog2(DEPTH):0]     fifo_count;
    logic                       lcd_on;
    logic                       lcd_rs;
    logic                       lcd_rw;
    logic                       lcd_en;
    logic [7:0]                 lcd_data;

    lcd_ctrl_if wr_bus ();

    lcd_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .SETUP_CYC  (S),
        .EN_CYC     (E),
        .HOLD_CYC   (H),
        .EXEC_CYC   (X),
        .CLR_CYC    (C),
        .PWRUP_CYC  (PW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .wr           (wr_bus),
        .o_busy       (busy),
        .o_init_done  (init_done),
        .o_fifo_count (fifo_count),
        .o_lcd_on     (lcd_on),
        .o_lcd_rs     (lcd_rs),
        .o_lcd_rw     (lcd_rw),
        .o_lcd_en     (lcd_en),
        .o_lcd_data   (lcd_data)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Edge index: t is the number of rising edges seen so far.
    int t = 0;
    bit armed = 1'b0;

    // Reference model: accepted-byte queue plus the timestamps of the job on the pins.
    logic [8:0] mq[$];
    logic [8:0] iq[$];
    logic [8:0] cur = 9'd0;
    int         rise_t = -100;
    int         fall_t = -100;
    int         end_t  = 0;
    bit         exp_done = 1'b1;

    // Observed strobes.
    int         rise_q[$];
    int         fall_q[$];
    logic [8:0] strobe_q[$];
    logic       en_prev   = 1'b0;
    logic       done_prev = 1'b0;
    int         done_t    = -1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", tag, got, exp, t);
        end
    endtask

    function automatic bit is_clr(input logic [8:0] b);
        return (b[8] == 1'b0) && (b[7:1] == 7'd0) && (b[7:0] != 8'd0);
    endfunction

    // A byte started on edge p: EN high from p+S, low from p+S+E, next byte
    // may start one edge after the post-hold wait has elapsed.
    task automatic start_job(input logic [8:0] b);
        cur    = b;
        rise_t = t + S;
        fall_t = rise_t + E;
        end_t  = fall_t + H + (is_clr(b) ? C : X);
    endtask

    task automatic model_step();
        int sz;
        if (rst) begin
            mq.delete();
            cur    = 9'd0;
            rise_t = -100;
            fall_t = -100;
            armed  = 1'b1;
`ifdef LCD_INIT_EN
            iq       = {9'h038, 9'h00C, 9'h001, 9'h006};
            end_t    = t + PW;
            exp_done = 1'b0;
`else
            iq.delete();
            end_t    = t;
            exp_done = 1'b1;
`endif
        end else if (armed) begin
            sz = mq.size();
            if (!exp_done && iq.size() == 0 && t == end_t) begin
                exp_done = 1'b1;
            end
            if (t > end_t) begin
                if (iq.size() != 0) begin
                    start_job(iq.pop_front());
                end else if (exp_done && sz != 0) begin
                    start_job(mq.pop_front());
                end
            end
            if (wr_bus.wr_valid && sz != DEPTH) begin
                mq.push_back(wr_bus.wr_data);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        t++;
        model_step();
        #1;
        if (armed) begin
            check_eq("en",   32'(lcd_en),     32'((t >= rise_t) && (t < fall_t)));
            check_eq("rs",   32'(lcd_rs),     32'(cur[8]));
            check_eq("data", 32'(lcd_data),   32'(cur[7:0]));
            check_eq("cnt",  32'(fifo_count), 32'(mq.size()));
            check_eq("rdy",  32'(wr_bus.wr_ready), 32'(mq.size() != DEPTH));
            check_eq("busy", 32'(busy),       32'((t < end_t) || (mq.size() != 0) || (iq.size() != 0)));
            check_eq("done", 32'(init_done),  32'(exp_done));
            check_eq("rw",   32'(lcd_rw),     32'(0));
            check_eq("on",   32'(lcd_on),     32'(1));
        end
        if (lcd_en === 1'b1 && en_prev === 1'b0) begin
            rise_q.push_back(t);
            strobe_q.push_back({lcd_rs, lcd_data});
        end
        if (lcd_en === 1'b0 && en_prev === 1'b1) begin
            fall_q.push_back(t);
        end
        en_prev = lcd_en;
        if (init_done === 1'b1 && done_prev !== 1'b1) begin
            done_t = t;
        end
        done_prev = init_done;
    endtask

    task automatic drive(input logic v, input logic [8:0] d);
        wr_bus.wr_valid = v;
        wr_bus.wr_data  = d;
    endtask

    task automatic push1(input logic [8:0] d);
        drive(1'b1, d);
        tick();
        drive(1'b0, 9'd0);
    endtask

    task automatic idle_wait(input int budget, input string tag);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(busy), 32'(0));
    endtask

    task automatic wait_init(input int budget);
        int n = 0;
        while (!init_done && n < budget) begin
            tick();
            n++;
        end
        check_eq("init_wait", 32'(init_done), 32'(1));
    endtask

    task automatic do_reset();
        drive(1'b0, 9'd0);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        wait_init(400);
    endtask

`ifdef LCD_INIT_EN
    task automatic scen_init();
        int r;
        drive(1'b0, 9'd0);
        rst = 1'b1;
        tick();
        r = t;
        check_eq("s6_done_low", 32'(init_done), 32'(0));
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) tick();
        push1(9'h177);
        wait_init(400);
        idle_wait(300, "s6_idle");
        // Power-up wait, one INIT edge, then setup before the first EN.
        check_eq("s6_first_rise", 32'(rise_q[0] - r), 32'(PW + 1 + S));
        check_eq("s6_byte0", 32'(strobe_q[0]), 32'h038);
        check_eq("s6_byte1", 32'(strobe_q[1]), 32'h00C);
        check_eq("s6_byte2", 32'(strobe_q[2]), 32'h001);
        check_eq("s6_byte3", 32'(strobe_q[3]), 32'h006);
        check_eq("s6_user",  32'(strobe_q[4]), 32'h177);
        check_eq("s6_after_done", 32'(rise_q[4] > done_t), 32'(1));
    endtask
`endif

    task automatic scen1();
        int t0;
        int r0;
        int n;
        do_reset();
        tick();
        r0 = rise_q.size();
        push1(9'h141);
        t0 = t;
        tick();
        check_eq("s1_rs",   32'(lcd_rs),   32'(1));
        check_eq("s1_data", 32'(lcd_data), 32'h41);
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        // From the push edge: IDLE pop + setup + pulse + hold + exec wait.
        check_eq("s1_busy_lat", 32'(t - t0), 32'(1 + S + E + H + X));
        check_eq("s1_rise_lat", 32'(rise_q[r0] - t0), 32'(1 + S));
        check_eq("s1_en_width", 32'(fall_q[r0] - rise_q[r0]), 32'(E));
        check_eq("s1_strobe",   32'(strobe_q[r0]), 32'h141);
    endtask

    task automatic scen2();
        int t0;
        int r0;
        do_reset();
        tick();
        r0 = rise_q.size();
        push1(9'h001);
        t0 = t;
        push1(9'h141);
        idle_wait(300, "s2_idle");
        check_eq("s2_rise_gap",    32'(rise_q[r0 + 1] - rise_q[r0]), 32'(E + H + C + 1 + S));
        check_eq("s2_pop_to_rise", 32'(rise_q[r0 + 1] - (t0 + 1)),   32'(S + E + H + C + 1 + S));
        check_eq("s2_first",  32'(strobe_q[r0]),     32'h001);
        check_eq("s2_second", 32'(strobe_q[r0 + 1]), 32'h141);
    endtask

    task automatic scen3();
        int r0;
        do_reset();
        tick();
        r0 = rise_q.size();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 9'(9'h150 + i));
            tick();
            if (i == 4) begin
                check_eq("s3_full_rdy", 32'(wr_bus.wr_ready), 32'(0));
                check_eq("s3_full_cnt", 32'(fifo_count),      32'(DEPTH));
            end
        end
        drive(1'b0, 9'd0);
        idle_wait(600, "s3_idle");
        // Byte 0 was popped one edge after its push, so bytes 0..4 fit; byte 5 is dropped.
        check_eq("s3_n_strobes", 32'(rise_q.size() - r0), 32'(5));
        for (int i = 0; i < 5; i++) begin
            check_eq("s3_order", 32'(strobe_q[r0 + i]), 32'(9'h150 + i));
        end
    endtask

    task automatic scen4();
        do_reset();
        tick();
        push1(9'h155);
        for (int k = 0; k < 4; k++) tick();
        check_eq("s4_en_mid", 32'(lcd_en), 32'(1));
        rst = 1'b1;
        tick();
        check_eq("s4_rst_en",   32'(lcd_en),     32'(0));
        check_eq("s4_rst_cnt",  32'(fifo_count), 32'(0));
        check_eq("s4_rst_busy", 32'(busy),       32'(RST_BUSY));
        rst = 1'b0;
        wait_init(400);
        push1(9'h142);
        idle_wait(300, "s4_idle");
        check_eq("s4_after", 32'(strobe_q[strobe_q.size() - 1]), 32'h142);
    endtask

    task automatic scen5();
        do_reset();
        tick();
        push1(9'h160);
        // Next pop lands one edge after the exec wait of the first byte.
        for (int k = 1; k <= 1 + S + E + H + X + 1; k++) begin
            drive((k == 5) || (k == 6) || (k == 1 + S + E + H + X + 1), 9'(9'h160 + k));
            tick();
            if (k == 1 + S + E + H + X) begin
                check_eq("s5_cnt_before", 32'(fifo_count), 32'(2));
            end
        end
        drive(1'b0, 9'd0);
        check_eq("s5_cnt_same", 32'(fifo_count),      32'(2));
        check_eq("s5_rdy_same", 32'(wr_bus.wr_ready), 32'(1));
        idle_wait(400, "s5_idle");
    endtask

    task automatic scen_random();
        logic [8:0] d;
        int rate;
        for (int i = 0; i < 3000; i++) begin
            rate = (i < 1500) ? 3 : 25;
            rst  = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, rate - 1) == 0) begin
                case ($urandom_range(0, 7))
                    0:       d = 9'h001;
                    1:       d = 9'h002;
                    default: d = 9'($urandom);
                endcase
                drive(1'b1, d);
            end else begin
                drive(1'b0, 9'd0);
            end
            tick();
        end
        rst = 1'b0;
        drive(1'b0, 9'd0);
        idle_wait(5000, "rand_drain");
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 9'd0);
`ifdef LCD_INIT_EN
        scen_init();
`endif
        scen1();
        scen2();
        scen3();
        scen4();
        scen5();
        scen_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", t);
        $fatal(1, "watchdog");
    end

endmodule
